ram_march_bist: RTL and testbench
=================================

RAM_MARCH_BIST -- requirements
Module: ram_march_bist

Interface
REQ-001 SHALL have parameter DATA_W, default 8: RAM word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 6: RAM address width; depth is 2**ADDR_W (64).
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1: single-cycle run request.
REQ-006 SHALL have port mem_addr, output, ADDR_W: RAM address.
REQ-007 SHALL have port mem_data, output, DATA_W: RAM write data.
REQ-008 SHALL have port mem_en, output, 1: RAM write enable; low means the RAM latches mem_addr for read.
REQ-009 SHALL have port mem_q, input, DATA_W: RAM read data, valid the cycle after the read address is presented with mem_en low.
REQ-010 SHALL have port busy, output, 1: test in progress.
REQ-011 SHALL have port done, output, 1: sticky run-complete flag.
REQ-012 SHALL have port pass, output, 1: valid when done=1; 1 means no mismatch.
REQ-013 SHALL have ports fail_addr (ADDR_W), fail_exp (DATA_W) and fail_got (DATA_W), all outputs: address, expected word and read word of the first mismatch.

Function
REQ-014 SHALL run the March C- subset as four elements:
- M0: ascending, write 0x00.
- M1: ascending, read 0x00 then write 0xFF.
- M2: descending, read 0xFF then write 0x00.
- M3: ascending, read 0x00.
REQ-015 SHALL use FSM states IDLE, WR, RD, CMP, DONE.
- IDLE -> WR on start.
- WR: mem_en=1, one cycle per address.
- RD: mem_en=0, mem_addr=A.
- CMP: compare mem_q with the expected value; in M1/M2 also drive mem_en=1, mem_addr=A, mem_data=new pattern.
- CMP -> RD at the next address, or to the next element at the terminal address.
- After M3 at the top address -> DONE.
REQ-016 SHALL register all outputs (Moore outputs, no combinational path from mem_q or start to any output).
REQ-017 SHALL hold busy=1 for exactly 64 + 3*64*2 = 448 cycles, starting the cycle after start is sampled.
REQ-018 SHALL, in the cycle after the final M3 CMP, set done=1 and busy=0, and move to DONE with mem_en=0.
REQ-019 SHALL latch fail_addr, fail_exp and fail_got only on the first mismatch of a run, and SHALL set pass=0 at done when any mismatch occurred.
REQ-020 SHALL ignore start while busy=1.
REQ-021 SHALL, on start in DONE, clear done, pass and the fail_* outputs and begin a new run.
REQ-022 SHALL handle address wrap explicitly: the ascending terminal address is 63 and the descending terminal address is 0; the counter never wraps silently.
REQ-023 SHALL hold mem_en=0 in IDLE and DONE.

Reset
REQ-024 SHALL, while rst_n=0, immediately force all outputs to zero and the state to IDLE, including during an active run.
REQ-025 SHALL NOT resume an aborted run after reset deasserts; a new start is required.

Configuration
REQ-026 SHALL compile the macro RAM_BIST_STOP_ON_FAIL_EN in or out.
- Defined: on the first mismatch, go to DONE on the next cycle with done=1 and pass=0.
- Undefined: the run always completes all 448 cycles, and fail_* report the first mismatch.

Structure
REQ-027 SHALL place in package ram_bist_pkg:
- the FSM state enum;
- the march-element enum (M0..M3);
- constants PAT0=8'h00 and PAT1=8'hFF;
- the per-element direction and expected/write-pattern lookup.
REQ-028 SHALL instantiate one sub-module ram_bist_addr_gen: a loadable up/down ADDR_W counter with a terminal-count flag.

Verification
REQ-029 Fault-free 8x64 RAM model; pulse start -> busy for 448 cycles, then done=1, pass=1, all RAM words 0x00.
REQ-030 Bit 3 of address 0x15 stuck at 1 -> done=1, pass=0, fail_addr=0x15, fail_exp=0x00, fail_got=0x08 (detected in M1).
REQ-031 Same fault with RAM_BIST_STOP_ON_FAIL_EN defined -> done rises 109 cycles after start (64 M0 cycles + 44 M1 cycles + 1), with mem_en=0 thereafter.
REQ-032 rst_n pulsed low mid-M2 -> all outputs 0 within the same cycle; a later start gives a full 448-cycle run with pass=1.
REQ-033 start re-pulsed at cycle 100 of a run -> no effect (total still 448); start pulsed in DONE -> done clears next cycle and a new run begins.

Source files
------------

// File: rtl/ram_bist_pkg.sv
// Shared types and march-element lookup for the RAM March C- BIST.
package ram_bist_pkg;

    localparam logic [7:0] PAT0 = 8'h00;
    localparam logic [7:0] PAT1 = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        CMP,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        M0,
        M1,
        M2,
        M3
    } elem_e;

    // Only M2 walks the array top-down.
    function automatic logic elem_up(elem_e e);
        return e != M2;
    endfunction

    function automatic logic [7:0] elem_exp_pat(elem_e e);
        return (e == M2) ? PAT1 : PAT0;
    endfunction

    function automatic logic [7:0] elem_wr_pat(elem_e e);
        return (e == M1) ? PAT1 : PAT0;
    endfunction

    function automatic logic elem_cmp_writes(elem_e e);
        return (e == M1) || (e == M2);
    endfunction

    function automatic elem_e elem_next(elem_e e);
        case (e)
            M0:      return M1;
            M1:      return M2;
            M2:      return M3;
            default: return M3;
        endcase
    endfunction

endpackage

// File: rtl/ram_bist_addr_gen.sv
// Loadable up/down address counter; it saturates at the terminal address
// instead of wrapping, so the FSM must reload it at each element boundary.
module ram_bist_addr_gen #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              step,
    input  logic              up,
    output logic [ADDR_W-1:0] cnt,
    output logic              tc_c
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    assign cnt  = cnt_q;
    assign tc_c = up ? (cnt_q == ADDR_MAX) : (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (step && !tc_c) begin
            cnt_d = up ? cnt_q + ADDR_W'(1) : cnt_q - ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ram_march_bist.sv
// March C- subset BIST controller (M0 w0 up, M1 r0/w1 up, M2 r1/w0 down, M3 r0 up).
// Define RAM_BIST_STOP_ON_FAIL_EN to end the run on the first mismatch.
module ram_march_bist
    import ram_bist_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_en,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_e            state_q, state_d;
    elem_e             elem_q, elem_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              mem_en_q, mem_en_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_exp_q, fail_exp_d;
    logic [DATA_W-1:0] fail_got_q, fail_got_d;

    logic              ag_load;
    logic [ADDR_W-1:0] ag_load_val;
    logic              ag_step;
    logic [ADDR_W-1:0] ag_cnt;
    logic              ag_tc_c;

    logic [7:0]        exp_pat_c;
    logic [7:0]        wr_pat_c;
    logic [DATA_W-1:0] data_exp_c;
    logic              mismatch_c;
    logic              stop_c;

    ram_bist_addr_gen #(
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (ag_load),
        .load_val(ag_load_val),
        .step    (ag_step),
        .up      (elem_up(elem_q)),
        .cnt     (ag_cnt),
        .tc_c    (ag_tc_c)
    );

    assign exp_pat_c  = elem_exp_pat(elem_q);
    assign data_exp_c = {DATA_W{exp_pat_c[0]}};
    assign mismatch_c = (state_q == CMP) && (mem_q != data_exp_c);

`ifdef RAM_BIST_STOP_ON_FAIL_EN
    assign stop_c = mismatch_c;
`else
    assign stop_c = 1'b0;
`endif

    // Next-state, counter control and registered-output values.
    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        err_d       = err_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_got_d  = fail_got_q;
        ag_load     = 1'b0;
        ag_load_val = '0;
        ag_step     = 1'b0;
        wr_pat_c    = PAT0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = WR;
                    elem_d      = M0;
                    err_d       = 1'b0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_exp_d  = '0;
                    fail_got_d  = '0;
                    ag_load     = 1'b1;
                end
            end
            WR: begin
                if (ag_tc_c) begin
                    state_d = RD;
                    elem_d  = M1;
                    ag_load = 1'b1;
                end else begin
                    ag_step = 1'b1;
                end
            end
            RD: begin
                state_d = CMP;
            end
            CMP: begin
                if (mismatch_c) begin
                    err_d = 1'b1;
                    if (!err_q) begin
                        fail_addr_d = ag_cnt;
                        fail_exp_d  = data_exp_c;
                        fail_got_d  = mem_q;
                    end
                end
                if (stop_c) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    pass_d  = 1'b0;
                end else if (ag_tc_c) begin
                    if (elem_q == M3) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = !(err_q || mismatch_c);
                    end else begin
                        state_d     = RD;
                        elem_d      = elem_next(elem_q);
                        ag_load     = 1'b1;
                        ag_load_val = elem_up(elem_next(elem_q)) ? '0 : ADDR_MAX;
                    end
                end else begin
                    state_d = RD;
                    ag_step = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d   = (state_d == WR) || (state_d == RD) || (state_d == CMP);
        mem_en_d = (state_d == WR) || ((state_d == CMP) && elem_cmp_writes(elem_d));
        wr_pat_c = elem_wr_pat(elem_d);
        mem_data_d = mem_en_d ? {DATA_W{wr_pat_c[0]}} : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            elem_q      <= M0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_data_q  <= '0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_got_q  <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            mem_en_q    <= mem_en_d;
            mem_data_q  <= mem_data_d;
            fail_addr_q <= fail_addr_d;
            fail_exp_q  <= fail_exp_d;
            fail_got_q  <= fail_got_d;
        end
    end

    assign mem_addr  = ag_cnt;
    assign mem_data  = mem_data_q;
    assign mem_en    = mem_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_addr = fail_addr_q;
    assign fail_exp  = fail_exp_q;
    assign fail_got  = fail_got_q;

endmodule

// File: tb/tb_ram_march_bist.sv
// Scoreboard bench for ram_march_bist with an 8x64 RAM model and optional stuck-at fault.
module tb_ram_march_bist;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DEPTH  = 64;
    localparam int FULL_CYC = 448;
`ifdef RAM_BIST_STOP_ON_FAIL_EN
    localparam int FAULT_CYC = 108;
`else
    localparam int FAULT_CYC = 448;
`endif

    typedef struct {
        logic              pass;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] e;
        logic [DATA_W-1:0] g;
        int                cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_en;
    logic [DATA_W-1:0] mem_q;
    logic              busy, done, pass;
    logic [ADDR_W-1:0] fail_addr;
    logic [DATA_W-1:0] fail_exp, fail_got;

    logic [DATA_W-1:0] ram [DEPTH];
    logic              fault_en = 1'b0;
    exp_t              exp_q [$];
    exp_t              ex;
    int                checks = 0;
    int                passes = 0;
    int                bcount = 0;
    logic              done_prev = 1'b0;

    always #5 clk = ~clk;

    ram_march_bist #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_en   (mem_en),
        .mem_q    (mem_q),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .fail_addr(fail_addr),
        .fail_exp (fail_exp),
        .fail_got (fail_got)
    );

    // RAM model: bit 3 of address 0x15 reads as 1 when the fault is enabled.
    always @(posedge clk) begin
        if (mem_en) begin
            ram[mem_addr] <= mem_data;
        end else begin
            mem_q <= ram[mem_addr] |
                     ((fault_en && mem_addr == 6'h15) ? 8'h08 : 8'h00);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got === expv) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, expv);
    endtask

    // Monitor: count busy cycles per run and score each rising done.
    always @(negedge clk) begin
        if (!rst_n) begin
            bcount    = 0;
            done_prev = 1'b0;
        end else begin
            if (busy) bcount++;
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_done", 32'(exp_q.size()), 32'd1);
                end else begin
                    ex = exp_q.pop_front();
                    check("sb_pass",      32'(pass),      32'(ex.pass));
                    check("sb_fail_addr", 32'(fail_addr), 32'(ex.addr));
                    check("sb_fail_exp",  32'(fail_exp),  32'(ex.e));
                    check("sb_fail_got",  32'(fail_got),  32'(ex.g));
                    check("sb_busy_cyc",  32'(bcount),    32'(ex.cyc));
                    check("sb_done_mem_en_busy", {30'd0, mem_en, busy}, 32'd0);
                end
                bcount = 0;
            end
            done_prev = done;
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) check(name, 32'(done), 32'd1);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {busy, done, pass, mem_en, 4'd0, mem_addr, 2'd0,
                     mem_data, fail_addr, 2'd0}, 32'd0);
        check({name, "_fail_data"}, {16'd0, fail_exp, fail_got}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) ram[i] = 8'hA5;
        #12;
        check_all_zero("reset_outputs");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_reset", {30'd0, busy, done}, 32'd0);

        // Fault-free run with start re-pulsed around cycle 100.
        exp_q.push_back('{1'b1, 6'h00, 8'h00, 8'h00, FULL_CYC});
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        repeat (98) @(posedge clk);
        #1;
        pulse_start();
        wait_done("run1_timeout");
        begin
            logic [DATA_W-1:0] acc;
            acc = '0;
            for (int i = 0; i < int'(DEPTH); i++) acc = acc | ram[i];
            check("ram_all_zero", 32'(acc), 32'd0);
        end

        // Start from DONE clears done and begins a new run.
        exp_q.push_back('{1'b1, 6'h00, 8'h00, 8'h00, FULL_CYC});
        pulse_start();
        check("restart_from_done", {30'd0, done, busy}, 32'd1);
        wait_done("run2_timeout");

        // Stuck-at-1 on bit 3 of address 0x15, caught in M1.
        fault_en = 1'b1;
        exp_q.push_back('{1'b0, 6'h15, 8'h00, 8'h08, FAULT_CYC});
        pulse_start();
        check("fault_run_clears", {29'd0, done, pass, busy}, 32'd1);
        wait_done("fault_timeout");
        repeat (4) @(posedge clk);
        #1;
        check("fault_done_hold", {29'd0, done, mem_en, busy}, 32'd4);
        fault_en = 1'b0;

        // Reset in the middle of M2, then no resume.
        pulse_start();
        repeat (212) @(posedge clk);
        #1;
        check("mid_run_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("no_resume", {30'd0, busy, done}, 32'd0);

        exp_q.push_back('{1'b1, 6'h00, 8'h00, 8'h00, FULL_CYC});
        pulse_start();
        wait_done("post_reset_timeout");
        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
